// File: rtl/uart_tx_peripheral.sv
// Purpose: memory-mapped 8N1 UART transmitter with a byte FIFO and status/control registers.
// Latency: a store into an empty FIFO while idle drives the start bit one clock later; reads are combinational.
// Backpressure: none toward the CPU; a store to a full FIFO is dropped and sets the sticky overflow flag.
module uart_tx_peripheral #(
   parameter logic [2:0] PERIPH_ID    = 3'd2,
   parameter int         CLKS_PER_BIT = 234,
   parameter int         FIFO_DEPTH   = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr,
   input  logic [31:0] data_in,
   input  logic        write_enable,
   output logic [31:0] data_out,
   output logic        tx,
   output logic        busy
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t          state_q, state_d;
   logic [BW-1:0]   baud_q, baud_d;
   logic [2:0]      bit_idx_q, bit_idx_d;
   logic [7:0]      shift_q, shift_d;
   logic            tx_q, tx_d;
   logic            busy_q, busy_d;
   logic [7:0]      mem_q [FIFO_DEPTH];
   logic [7:0]      mem_d [FIFO_DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            overflow_q, overflow_d;
   logic            enable_q, enable_d;

   logic            sel, wr_txdata, wr_status, wr_ctrl;
   logic            full, empty, push, pop, baud_end;
   logic [1:0]      offset;
   logic [31:0]     status_w;
   logic            unused_bits;

   // Bus decode; fullness comes from the pre-edge count so a same-cycle pop never rescues a store
   always_comb begin
      offset    = addr[3:2];
      sel       = (addr[31:29] == PERIPH_ID);
      wr_txdata = sel && write_enable && (offset == 2'd0);
      wr_status = sel && write_enable && (offset == 2'd1);
      wr_ctrl   = sel && write_enable && (offset == 2'd2);
      full      = (count_q == DEPTH_C);
      empty     = (count_q == '0);
      push      = wr_txdata && !full;
      pop       = (state_q == S_IDLE) && enable_q && !empty;
      baud_end  = (baud_q == BAUD_LAST);
   end

   assign unused_bits = ^{addr[28:4], addr[1:0], data_in[31:8]};

   // FIFO storage, pointers, occupancy and the overflow/enable registers
   always_comb begin
      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      enable_d   = enable_q;
      if (push) begin
         mem_d[wr_ptr_q] = data_in[7:0];
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (push && !pop) begin
         count_d = count_q + CW'(1);
      end else if (!push && pop) begin
         count_d = count_q - CW'(1);
      end
      if (wr_status && data_in[3]) begin
         overflow_d = 1'b0;
      end
      if (wr_txdata && full) begin
         overflow_d = 1'b1;
      end
      if (wr_ctrl) begin
         enable_d = data_in[0];
      end
   end

   // Serialiser: every bit state lasts one full baud count; tx/busy follow next-state values
   always_comb begin
      state_d   = state_q;
      baud_d    = baud_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      case (state_q)
         S_IDLE: begin
            if (pop) begin
               shift_d = mem_q[rd_ptr_q];
               baud_d  = '0;
               state_d = S_START;
            end
         end
         S_START: begin
            if (baud_end) begin
               baud_d    = '0;
               bit_idx_d = 3'd0;
               state_d   = S_DATA;
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
         S_DATA: begin
            if (baud_end) begin
               baud_d = '0;
               if (bit_idx_q == 3'd7) begin
                  state_d = S_STOP;
               end else begin
                  shift_d   = shift_q >> 1;
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
         default: begin
            if (baud_end) begin
               baud_d  = '0;
               state_d = S_IDLE;
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
      endcase
      case (state_d)
         S_START: tx_d = 1'b0;
         S_DATA:  tx_d = shift_d[0];
         default: tx_d = 1'b1;
      endcase
      busy_d = (state_d != S_IDLE) || (count_d != '0);
   end

   // Register read mux; reads have no side effects
   always_comb begin
      status_w           = '0;
      status_w[4 +: CW]  = count_q;
      status_w[3]        = overflow_q;
      status_w[2]        = (state_q != S_IDLE);
      status_w[1]        = empty;
      status_w[0]        = full;
      data_out           = '0;
      if (sel) begin
         case (offset)
            2'd1:    data_out = status_w;
            2'd2:    data_out = {31'b0, enable_q};
            default: data_out = '0;
         endcase
      end
   end

   // State registers; reset aborts any frame and parks the line high
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         baud_q     <= '0;
         bit_idx_q  <= '0;
         shift_q    <= '0;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         enable_q   <= 1'b1;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         baud_q     <= baud_d;
         bit_idx_q  <= bit_idx_d;
         shift_q    <= shift_d;
         tx_q       <= tx_d;
         busy_q     <= busy_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         enable_q   <= enable_d;
         mem_q      <= mem_d;
      end
   end

   assign tx   = tx_q;
   assign busy = busy_q;

endmodule

// File: tb/tb_uart_tx_peripheral.sv
// Bench for uart_tx_peripheral with a short baud period.
// Register accesses come from a vector table; frames are checked clock by clock.
// Multi-cycle corners (back-to-back frames, mid-frame reset) use hand-written sequences.
module tb_uart_tx_peripheral;

   localparam int CPB = 4;
   localparam int FRAME = 10 * CPB;
   localparam logic [31:0] A_TXDATA = 32'h4000_0000;
   localparam logic [31:0] A_STATUS = 32'h4000_0004;
   localparam logic [31:0] A_CTRL   = 32'h4000_0008;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] addr;
   logic [31:0] data_in;
   logic        write_enable;
   logic [31:0] data_out;
   logic        tx;
   logic        busy;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        we;
      logic [31:0] a;
      logic [31:0] wdata;
      logic [31:0] exp_dout;
      logic        exp_busy;
   } vec_t;

   vec_t vecs [25];

   uart_tx_peripheral #(
      .PERIPH_ID   (3'd2),
      .CLKS_PER_BIT(CPB),
      .FIFO_DEPTH  (8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .addr        (addr),
      .data_in     (data_in),
      .write_enable(write_enable),
      .data_out    (data_out),
      .tx          (tx),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic set_vec(input int i, input logic we, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] dout, input logic bsy);
      vecs[i].we       = we;
      vecs[i].a        = a;
      vecs[i].wdata    = wd;
      vecs[i].exp_dout = dout;
      vecs[i].exp_busy = bsy;
   endtask

   // Samples frame clocks first..last-1; clock 0 is the one right after the pop edge.
   task automatic expect_frame(input logic [7:0] b, input int first, input int last);
      for (int k = first; k < last; k++) begin
         int   slot;
         logic e;
         @(posedge clk);
         #1;
         slot = k / CPB;
         if (slot == 0)      e = 1'b0;
         else if (slot == 9) e = 1'b1;
         else                e = b[slot-1];
         chk($sformatf("frame %02h clk %0d tx", b, k), {31'b0, tx}, {31'b0, e});
         chk($sformatf("frame %02h clk %0d busy", b, k), {31'b0, busy}, 32'd1);
      end
   endtask

   task automatic idle_check(input string name, input logic exp_busy);
      @(posedge clk);
      #1;
      chk({name, " idle tx"}, {31'b0, tx}, 32'd1);
      chk({name, " idle busy"}, {31'b0, busy}, {31'b0, exp_busy});
   endtask

   task automatic quiet_line(input string name, input int n);
      int bad = 0;
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
         if (tx !== 1'b1) bad++;
      end
      chk({name, " tx low clocks"}, bad, 32'd0);
   endtask

   task automatic read_status(input string name, input logic [31:0] exp);
      addr = A_STATUS;
      #1;
      chk(name, data_out, exp);
   endtask

   initial begin
      rst = 1'b0;
      addr = '0;
      data_in = '0;
      write_enable = 1'b0;

      set_vec(0,  1'b0, A_STATUS,       32'h0,        32'h0000_0002, 1'b0);
      set_vec(1,  1'b0, A_CTRL,         32'h0,        32'h0000_0001, 1'b0);
      set_vec(2,  1'b0, 32'h4000_000C,  32'h0,        32'h0,         1'b0);
      set_vec(3,  1'b0, A_TXDATA,       32'h0,        32'h0,         1'b0);
      set_vec(4,  1'b1, A_CTRL,         32'h0,        32'h0000_0001, 1'b0);
      set_vec(5,  1'b0, A_CTRL,         32'h0,        32'h0,         1'b0);
      set_vec(6,  1'b1, 32'h2000_0000,  32'h77,       32'h0,         1'b0);
      set_vec(7,  1'b0, 32'h2000_0004,  32'h0,        32'h0,         1'b0);
      set_vec(8,  1'b0, A_STATUS,       32'h0,        32'h0000_0002, 1'b0);
      for (int i = 0; i < 9; i++) begin
         set_vec(9 + i, 1'b1, A_TXDATA, 32'(16 + i), 32'h0, (i != 0));
      end
      set_vec(18, 1'b0, 32'h5FFF_FFF7,  32'h0,        32'h0000_0089, 1'b1);
      set_vec(19, 1'b1, 32'h4000_000C,  32'hFFFF_FFFF, 32'h0,        1'b1);
      set_vec(20, 1'b1, A_STATUS,       32'h7,        32'h0000_0089, 1'b1);
      set_vec(21, 1'b0, A_STATUS,       32'h0,        32'h0000_0089, 1'b1);
      set_vec(22, 1'b1, A_STATUS,       32'h8,        32'h0000_0089, 1'b1);
      set_vec(23, 1'b0, A_STATUS,       32'h0,        32'h0000_0081, 1'b1);
      set_vec(24, 1'b1, A_CTRL,         32'h1,        32'h0,         1'b1);

      repeat (3) @(posedge clk);
      #1;
      chk("reset tx", {31'b0, tx}, 32'd1);
      chk("reset busy", {31'b0, busy}, 32'd0);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // register table: reset reads, slot decode, overflow and its clear, enable
      for (int i = 0; i < 25; i++) begin
         addr         = vecs[i].a;
         data_in      = vecs[i].wdata;
         write_enable = vecs[i].we;
         #1;
         chk($sformatf("vec %0d data_out", i), data_out, vecs[i].exp_dout);
         chk($sformatf("vec %0d tx", i), {31'b0, tx}, 32'd1);
         chk($sformatf("vec %0d busy", i), {31'b0, busy}, {31'b0, vecs[i].exp_busy});
         @(posedge clk);
         #1;
         write_enable = 1'b0;
      end

      // the eight buffered bytes drain in order with one idle clock between frames
      for (int i = 0; i < 8; i++) begin
         expect_frame(8'(16 + i), 0, FRAME);
         idle_check($sformatf("drain %0d", i), (i != 7));
      end
      quiet_line("after drain", 3 * FRAME);
      read_status("drained status", 32'h0000_0002);

      // single frame 0x55
      addr = A_TXDATA;
      data_in = 32'h55;
      write_enable = 1'b1;
      @(posedge clk);
      #1;
      write_enable = 1'b0;
      chk("0x55 store-edge tx", {31'b0, tx}, 32'd1);
      chk("0x55 store-edge busy", {31'b0, busy}, 32'd1);
      expect_frame(8'h55, 0, FRAME);
      idle_check("0x55", 1'b0);

      // back-to-back 0xA5, 0x3C: second store coincides with the first pop
      addr = A_TXDATA;
      data_in = 32'hA5;
      write_enable = 1'b1;
      @(posedge clk);
      #1;
      data_in = 32'h3C;
      @(posedge clk);
      #1;
      write_enable = 1'b0;
      chk("b2b start tx", {31'b0, tx}, 32'd0);
      read_status("b2b status count 1", 32'h0000_0014);
      expect_frame(8'hA5, 1, FRAME);
      idle_check("b2b gap", 1'b1);
      expect_frame(8'h3C, 0, FRAME);
      idle_check("b2b end", 1'b0);

      // reset during data bit 3 with another byte still queued
      addr = A_TXDATA;
      data_in = 32'hF0;
      write_enable = 1'b1;
      @(posedge clk);
      #1;
      data_in = 32'h00;
      @(posedge clk);
      #1;
      write_enable = 1'b0;
      expect_frame(8'hF0, 1, CPB * 4 + 2);
      rst = 1'b0;
      #1;
      chk("mid-frame reset tx", {31'b0, tx}, 32'd1);
      chk("mid-frame reset busy", {31'b0, busy}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      read_status("post-reset status", 32'h0000_0002);
      chk("post-reset busy", {31'b0, busy}, 32'd0);
      quiet_line("post-reset", 2 * FRAME);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
